// File: rtl/apb_rr_arbiter_pkg.sv
// Shared constants for the round-robin APB arbiter: FSM encodings and APB field widths.
package apb_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = 4;

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Bundle of the NUM_REQ upstream requester ports, the shared downstream completer port and the grant vector.
interface apb_rr_arbiter_if #(parameter int NUM_REQ = 2);
  import apb_arb_pkg::*;

  logic [NUM_REQ-1:0]        psel_i;
  logic [NUM_REQ-1:0]        penable_i;
  logic [NUM_REQ-1:0]        pwrite_i;
  logic [APB_SW*NUM_REQ-1:0] pstrb_i;
  logic [APB_AW*NUM_REQ-1:0] paddr_i;
  logic [APB_DW*NUM_REQ-1:0] pwdata_i;
  logic [APB_DW*NUM_REQ-1:0] prdata_o;
  logic [NUM_REQ-1:0]        pready_o;

  logic                      psel_o;
  logic                      penable_o;
  logic                      pwrite_o;
  logic [APB_SW-1:0]         pstrb_o;
  logic [APB_AW-1:0]         paddr_o;
  logic [APB_DW-1:0]         pwdata_o;
  logic [APB_DW-1:0]         prdata_i;
  logic                      pready_i;

  logic [NUM_REQ-1:0]        grant_o;

  modport slave (
    input  psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i, prdata_i, pready_i,
    output prdata_o, pready_o, psel_o, penable_o, pwrite_o, pstrb_o, paddr_o, pwdata_o, grant_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i, prdata_i, pready_i,
    input  prdata_o, pready_o, psel_o, penable_o, pwrite_o, pstrb_o, paddr_o, pwdata_o, grant_o
  );

endinterface

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request found searching upward from last+1, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand_s;

  // Offsets are walked farthest-first so the nearest request after last overwrites the result.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    cand_s  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_s = IDX_W'((int'(last) + i) % NUM_REQ);
      if (req[cand_s]) begin
        gnt_idx = cand_s;
        any     = 1'b1;
      end else begin
        gnt_idx = gnt_idx;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one registered APB completer port among NUM_REQ requesters, one transfer per grant.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic             pclk,
  input  logic             preset,
  apb_rr_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [1:0]         state_r;
  logic [IDX_W-1:0]   win_r;
  logic [IDX_W-1:0]   last_r;
  logic [IDX_W-1:0]   pick_s;
  logic               any_s;
  logic [NUM_REQ-1:0] req_s;
  logic [NUM_REQ-1:0] pick_oh_s;
  logic [APB_AW-1:0]  sel_addr_s;
  logic [APB_DW-1:0]  sel_wdata_s;
  logic [APB_SW-1:0]  sel_strb_s;
  logic               sel_write_s;

  // Only requesters already in their ACCESS phase compete, so their attributes are stable.
  assign req_s = bus.psel_i & bus.penable_i;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req_s),
    .last    (last_r),
    .gnt_idx (pick_s),
    .any     (any_s)
  );

  // Select the picked requester's attributes and one-hot grant.
  always_comb begin
    pick_oh_s   = '0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_strb_s  = '0;
    sel_write_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_s == IDX_W'(k)) begin
        pick_oh_s[k] = 1'b1;
        sel_addr_s   = bus.paddr_i[k*APB_AW +: APB_AW];
        sel_wdata_s  = bus.pwdata_i[k*APB_DW +: APB_DW];
        sel_strb_s   = bus.pstrb_i[k*APB_SW +: APB_SW];
        sel_write_s  = bus.pwrite_i[k];
      end else begin
        pick_oh_s[k] = 1'b0;
      end
    end
  end

  // Transfer FSM with registered downstream port and per-requester response return.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r       <= IDLE;
      win_r         <= '0;
      last_r        <= IDX_W'(NUM_REQ - 1);
      bus.psel_o    <= 1'b0;
      bus.penable_o <= 1'b0;
      bus.pwrite_o  <= 1'b0;
      bus.pstrb_o   <= '0;
      bus.paddr_o   <= '0;
      bus.pwdata_o  <= '0;
      bus.grant_o   <= '0;
      bus.pready_o  <= '0;
      bus.prdata_o  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            win_r        <= pick_s;
            bus.paddr_o  <= sel_addr_s;
            bus.pwdata_o <= sel_wdata_s;
            bus.pstrb_o  <= sel_strb_s;
            bus.pwrite_o <= sel_write_s;
            bus.grant_o  <= pick_oh_s;
            bus.psel_o   <= 1'b1;
            state_r      <= SETUP;
          end
        end
        SETUP: begin
          bus.penable_o <= 1'b1;
          state_r       <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
              if (win_r == IDX_W'(k)) begin
                bus.prdata_o[k*APB_DW +: APB_DW] <= bus.prdata_i;
                bus.pready_o[k]                  <= 1'b1;
              end
            end
            bus.psel_o    <= 1'b0;
            bus.penable_o <= 1'b0;
            last_r        <= win_r;
            state_r       <= DONE;
          end
        end
        // Requests seen here wait for IDLE, which guarantees an idle bus cycle between transfers.
        DONE: begin
          bus.pready_o <= '0;
          bus.grant_o  <= '0;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scenario tasks with inline checks against bench-computed expectations for the round-robin APB arbiter.
module tb_apb_rr_arbiter;
  import apb_arb_pkg::*;

  typedef struct { int idx; logic [31:0] data; } done_t;

  logic pclk = 1'b0;
  logic preset;
  int   total = 0;
  int   bad = 0;

  always #5 pclk = ~pclk;

  apb_rr_arbiter_if #(.NUM_REQ(2)) b2 ();
  apb_rr_arbiter_if #(.NUM_REQ(4)) b4 ();

  apb_rr_arbiter #(.NUM_REQ(2)) d2 (.pclk(pclk), .preset(preset), .bus(b2));
  apb_rr_arbiter #(.NUM_REQ(4)) d4 (.pclk(pclk), .preset(preset), .bus(b4));

  // Completer models: pready after a programmable number of ACCESS wait cycles.
  int         wait2 = 0;
  logic [7:0] acc2 = 8'd0;
  logic [7:0] acc4 = 8'd0;
  always @(posedge pclk) begin
    if (preset || !(b2.psel_o && b2.penable_o) || b2.pready_i) acc2 <= 8'd0;
    else acc2 <= acc2 + 8'd1;
    if (preset || !(b4.psel_o && b4.penable_o) || b4.pready_i) acc4 <= 8'd0;
    else acc4 <= acc4 + 8'd1;
  end
  assign b2.pready_i = b2.psel_o && b2.penable_o && (int'(acc2) == wait2);
  assign b4.pready_i = b4.psel_o && b4.penable_o && (acc4 == {6'd0, b4.paddr_o[3:2]});
  assign b4.prdata_i = b4.paddr_o ^ 32'hA5A5_5A5A;

  // Requester model for the 2-port instance
  int          pend2[2];
  logic [31:0] addr2[2];
  logic [31:0] wdata2[2];
  logic [3:0]  strb2[2];
  logic        wr2[2];
  done_t       done2_q[$];
  done_t       exp_done_q[$];
  int          exp_idx_q[$];
  logic [31:0] obs_addr_q[$];
  logic [31:0] exp_addr_q[$];
  int          rdy_bad2 = 0;
  int          unstable2 = 0;
  logic [31:0] pa2 = 32'd0;
  logic [31:0] pw2 = 32'd0;
  logic [3:0]  ps2 = 4'd0;
  logic        pwr2 = 1'b0;

  task automatic step2();
    @(posedge pclk);
    #1;
    if ((b2.pready_o & ~b2.grant_o) != 2'b00 || $countones(b2.pready_o) > 1) rdy_bad2++;
    if (b2.psel_o && b2.penable_o && {b2.paddr_o, b2.pwdata_o, b2.pstrb_o, b2.pwrite_o} != {pa2, pw2, ps2, pwr2})
      unstable2++;
    pa2 = b2.paddr_o; pw2 = b2.pwdata_o; ps2 = b2.pstrb_o; pwr2 = b2.pwrite_o;
    if (b2.psel_o && b2.penable_o && b2.pready_i) obs_addr_q.push_back(b2.paddr_o);
    for (int k = 0; k < 2; k++) begin
      if (b2.pready_o[k]) begin
        done2_q.push_back('{k, b2.prdata_o[k*32 +: 32]});
        b2.psel_i[k] = 1'b0;
        b2.penable_i[k] = 1'b0;
      end else if (b2.psel_i[k] && !b2.penable_i[k]) begin
        b2.penable_i[k] = 1'b1;
      end else if (!b2.psel_i[k] && pend2[k] > 0) begin
        b2.psel_i[k] = 1'b1;
        b2.pwrite_i[k] = wr2[k];
        b2.paddr_i[k*32 +: 32] = addr2[k];
        b2.pwdata_i[k*32 +: 32] = wdata2[k];
        b2.pstrb_i[k*4 +: 4] = strb2[k];
        pend2[k]--;
      end
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) step2();
    total++;
    if ({b2.psel_o, b2.penable_o, b2.pready_o, b2.grant_o} !== 6'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {b2.psel_o, b2.penable_o, b2.pready_o, b2.grant_o});
    end
    total++;
    if ({b2.paddr_o, b2.pwdata_o, b2.pstrb_o, b2.pwrite_o} !== 69'd0) begin
      bad++; $display("FAIL reset_attr: got %h want 0", {b2.paddr_o, b2.pwdata_o, b2.pstrb_o, b2.pwrite_o});
    end
    total++;
    if (b2.prdata_o !== 64'd0) begin
      bad++; $display("FAIL reset_prdata: got %h want 0", b2.prdata_o);
    end
    total++;
    if ({b4.psel_o, b4.penable_o, b4.pready_o, b4.grant_o, b4.prdata_o} !== 138'd0) begin
      bad++; $display("FAIL reset_n4: got psel=%b pen=%b rdy=%b gnt=%b", b4.psel_o, b4.penable_o, b4.pready_o, b4.grant_o);
    end
    preset = 1'b0;
    step2();
  endtask

  task automatic test_single_write();
    done2_q.delete();
    wait2 = 0;
    b2.prdata_i = 32'hCAFE_0001;
    addr2[0] = 32'h40; wdata2[0] = 32'hDEAD_BEEF; strb2[0] = 4'hF; wr2[0] = 1'b1;
    pend2[0] = 1;
    step2(); step2(); step2();
    total++;
    if ({b2.psel_o, b2.penable_o, b2.grant_o} !== 4'b1001) begin
      bad++; $display("FAIL wr_setup: psel/pen/gnt got %b want 1001", {b2.psel_o, b2.penable_o, b2.grant_o});
    end
    total++;
    if ({b2.paddr_o, b2.pwdata_o, b2.pstrb_o, b2.pwrite_o} !== {32'h40, 32'hDEAD_BEEF, 4'hF, 1'b1}) begin
      bad++; $display("FAIL wr_attr_setup: got %h %h %h %b", b2.paddr_o, b2.pwdata_o, b2.pstrb_o, b2.pwrite_o);
    end
    step2();
    total++;
    if ({b2.psel_o, b2.penable_o, b2.pready_o, b2.paddr_o, b2.pwdata_o} !== {2'b11, 2'b00, 32'h40, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL wr_access: psel=%b pen=%b rdy=%b addr=%h wdata=%h", b2.psel_o, b2.penable_o, b2.pready_o, b2.paddr_o, b2.pwdata_o);
    end
    step2();
    total++;
    if ({b2.psel_o, b2.penable_o, b2.pready_o, b2.grant_o, b2.prdata_o[31:0]} !== {2'b00, 2'b01, 2'b01, 32'hCAFE_0001}) begin
      bad++; $display("FAIL wr_ready: psel=%b pen=%b rdy=%b gnt=%b prdata=%h", b2.psel_o, b2.penable_o, b2.pready_o, b2.grant_o, b2.prdata_o[31:0]);
    end
    step2();
    total++;
    if ({b2.pready_o, b2.grant_o} !== 4'b0000 || done2_q.size() != 1) begin
      bad++; $display("FAIL wr_done: rdy=%b gnt=%b pulses=%0d want 00 00 1", b2.pready_o, b2.grant_o, done2_q.size());
    end
    total++;
    if (unstable2 !== 0) begin
      bad++; $display("FAIL wr_stable: changes=%0d want 0", unstable2);
    end
  endtask

  task automatic test_contention();
    int n;
    preset = 1'b1; step2(); step2(); preset = 1'b0;
    done2_q.delete(); obs_addr_q.delete(); exp_idx_q.delete(); exp_addr_q.delete();
    rdy_bad2 = 0;
    addr2[0] = 32'h100; wdata2[0] = 32'hA0A0_0000; strb2[0] = 4'h3; wr2[0] = 1'b1;
    addr2[1] = 32'h104; wdata2[1] = 32'hB1B1_1111; strb2[1] = 4'hC; wr2[1] = 1'b1;
    pend2[0] = 2; pend2[1] = 2;
    exp_idx_q = '{0, 1, 0, 1};
    exp_addr_q = '{32'h100, 32'h104, 32'h100, 32'h104};
    n = 0;
    while (done2_q.size() < 4 && n < 200) begin step2(); n++; end
    total++;
    if (done2_q.size() != 4) begin
      bad++; $display("FAIL cont_timeout: got %0d completions want 4", done2_q.size());
    end
    while (done2_q.size() > 0 && exp_idx_q.size() > 0) begin
      done_t d;
      int e;
      d = done2_q.pop_front();
      e = exp_idx_q.pop_front();
      total++;
      if (d.idx !== e) begin bad++; $display("FAIL cont_order: got %0d want %0d", d.idx, e); end
    end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      logic [31:0] a;
      logic [31:0] ea;
      a = obs_addr_q.pop_front();
      ea = exp_addr_q.pop_front();
      total++;
      if (a !== ea) begin bad++; $display("FAIL cont_addr: got %h want %h", a, ea); end
    end
    total++;
    if (rdy_bad2 !== 0) begin bad++; $display("FAIL cont_rdy_owner: bad cycles=%0d want 0", rdy_bad2); end
  endtask

  task automatic test_read_wait();
    int n;
    int acc_n;
    done2_q.delete(); exp_done_q.delete();
    wait2 = 5;
    b2.prdata_i = 32'h1234_5678;
    addr2[0] = 32'h200; wdata2[0] = 32'h0; strb2[0] = 4'h0; wr2[0] = 1'b0;
    addr2[1] = 32'h300; wdata2[1] = 32'h5555_AAAA; strb2[1] = 4'hF; wr2[1] = 1'b1;
    pend2[0] = 1; pend2[1] = 1;
    exp_done_q.push_back('{0, 32'h1234_5678});
    exp_done_q.push_back('{1, 32'h0BAD_F00D});
    n = 0;
    do begin step2(); n++; end while (!b2.psel_o && n < 20);
    total++;
    if (b2.grant_o !== 2'b01) begin bad++; $display("FAIL rw_first: gnt got %b want 01", b2.grant_o); end
    acc_n = 0; n = 0;
    while (!b2.pready_o[0] && n < 40) begin
      step2(); n++;
      if (b2.penable_o) acc_n++;
    end
    total++;
    if (acc_n !== 6) begin bad++; $display("FAIL rw_access_len: got %0d want 6", acc_n); end
    total++;
    if ({b2.pready_o, b2.prdata_o[31:0]} !== {2'b01, 32'h1234_5678}) begin
      bad++; $display("FAIL rw_data: rdy=%b prdata=%h want 01 12345678", b2.pready_o, b2.prdata_o[31:0]);
    end
    wait2 = 0;
    b2.prdata_i = 32'h0BAD_F00D;
    step2();
    total++;
    if ({b2.grant_o, b2.psel_o} !== 3'b000) begin bad++; $display("FAIL rw_done_gap: gnt=%b psel=%b want 00 0", b2.grant_o, b2.psel_o); end
    step2();
    total++;
    if ({b2.grant_o, b2.psel_o} !== 3'b101) begin bad++; $display("FAIL rw_next_grant: gnt=%b psel=%b want 10 1", b2.grant_o, b2.psel_o); end
    n = 0;
    while (done2_q.size() < 2 && n < 20) begin step2(); n++; end
    while (done2_q.size() > 0 && exp_done_q.size() > 0) begin
      done_t d;
      done_t e;
      d = done2_q.pop_front();
      e = exp_done_q.pop_front();
      total++;
      if (d.idx !== e.idx || d.data !== e.data) begin
        bad++; $display("FAIL rw_scoreboard: got %0d/%h want %0d/%h", d.idx, d.data, e.idx, e.data);
      end
    end
    total++;
    if (exp_done_q.size() != 0 || b2.prdata_o[31:0] !== 32'h1234_5678) begin
      bad++; $display("FAIL rw_hold: missing=%0d slice0=%h want 0 12345678", exp_done_q.size(), b2.prdata_o[31:0]);
    end
  endtask

  task automatic test_drop_after_grant();
    int n;
    int hits;
    done2_q.delete();
    wait2 = 2;
    addr2[0] = 32'h500; wdata2[0] = 32'h1; strb2[0] = 4'h1; wr2[0] = 1'b1;
    pend2[0] = 1;
    n = 0;
    do begin step2(); n++; end while (!b2.psel_o && n < 20);
    b2.psel_i[0] = 1'b0; b2.penable_i[0] = 1'b0;
    b2.psel_i[1] = 1'b1; b2.penable_i[1] = 1'b1;
    step2();
    b2.psel_i[1] = 1'b0; b2.penable_i[1] = 1'b0;
    hits = 0;
    repeat (12) begin
      step2();
      if (b2.grant_o[1]) hits++;
    end
    total++;
    if (done2_q.size() != 1 || done2_q[0].idx != 0) begin
      bad++; $display("FAIL drop_late: pulses=%0d want 1 on requester 0", done2_q.size());
    end
    total++;
    if (hits !== 0) begin bad++; $display("FAIL drop_early: granted cycles=%0d want 0", hits); end
    wait2 = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    done2_q.delete();
    wait2 = 10;
    addr2[0] = 32'h600; wdata2[0] = 32'h2; strb2[0] = 4'hF; wr2[0] = 1'b1;
    pend2[0] = 1;
    n = 0;
    do begin step2(); n++; end while (!b2.penable_o && n < 20);
    step2();
    preset = 1'b1;
    step2();
    total++;
    if ({b2.psel_o, b2.penable_o, b2.pready_o, b2.grant_o} !== 6'd0) begin
      bad++; $display("FAIL rst_mid_outputs: got %b want 000000", {b2.psel_o, b2.penable_o, b2.pready_o, b2.grant_o});
    end
    total++;
    if (d2.state_r !== IDLE) begin bad++; $display("FAIL rst_mid_state: got %0d want %0d", d2.state_r, IDLE); end
    b2.psel_i = 2'b00; b2.penable_i = 2'b00; pend2[0] = 0;
    step2();
    preset = 1'b0;
    pulses = 0;
    repeat (6) begin
      step2();
      if (b2.pready_o != 2'b00 || b2.psel_o) pulses++;
    end
    total++;
    if (pulses !== 0 || done2_q.size() != 0) begin
      bad++; $display("FAIL rst_mid_quiet: activity=%0d pulses=%0d want 0 0", pulses, done2_q.size());
    end
    wait2 = 0;
  endtask

  task automatic test_random4();
    logic [31:0] ea[4];
    logic [31:0] ew[4];
    logic [3:0]  es[4];
    logic        ewr[4];
    int          waitg[4];
    logic [31:0] pa = 32'd0;
    logic [31:0] pw = 32'd0;
    logic [3:0]  ps = 4'd0;
    logic        pwr = 1'b0;
    int          served = 0;
    int          g;
    for (int k = 0; k < 4; k++) begin
      ea[k] = 32'd0; ew[k] = 32'd0; es[k] = 4'd0; ewr[k] = 1'b0; waitg[k] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(posedge pclk);
      #1;
      total++;
      if ($countones(b4.grant_o) > 1 || (b4.penable_o && !b4.psel_o) || (b4.pready_o & ~b4.grant_o) != 4'd0 ||
          (b4.psel_o && b4.penable_o && {b4.paddr_o, b4.pwdata_o, b4.pstrb_o, b4.pwrite_o} != {pa, pw, ps, pwr})) begin
        bad++;
        $display("FAIL rnd_proto cycle %0d: gnt=%b psel=%b pen=%b rdy=%b", c, b4.grant_o, b4.psel_o, b4.penable_o, b4.pready_o);
      end
      pa = b4.paddr_o; pw = b4.pwdata_o; ps = b4.pstrb_o; pwr = b4.pwrite_o;
      if (b4.psel_o && b4.penable_o && b4.pready_i) begin
        g = 0;
        for (int k = 0; k < 4; k++) if (b4.grant_o[k]) g = k;
        total++;
        if ({b4.paddr_o, b4.pwdata_o, b4.pstrb_o, b4.pwrite_o} !== {ea[g], ew[g], es[g], ewr[g]}) begin
          bad++; $display("FAIL rnd_mux req%0d: addr got %h want %h", g, b4.paddr_o, ea[g]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (b4.pready_o[k]) begin
          total++;
          if (b4.prdata_o[k*32 +: 32] !== (ea[k] ^ 32'hA5A5_5A5A) || waitg[k] > 3) begin
            bad++;
            $display("FAIL rnd_serve req%0d: prdata %h want %h, others served first %0d (max 3)",
                     k, b4.prdata_o[k*32 +: 32], ea[k] ^ 32'hA5A5_5A5A, waitg[k]);
          end
          served++;
          for (int j = 0; j < 4; j++) if (j != k && b4.psel_i[j] && b4.penable_i[j]) waitg[j]++;
          b4.psel_i[k] = 1'b0;
          b4.penable_i[k] = 1'b0;
        end else if (b4.psel_i[k] && !b4.penable_i[k]) begin
          b4.penable_i[k] = 1'b1;
          waitg[k] = 0;
        end else if (!b4.psel_i[k] && $urandom_range(0, 2) == 0) begin
          ea[k] = $urandom(); ew[k] = $urandom(); es[k] = 4'($urandom()); ewr[k] = 1'($urandom());
          b4.paddr_i[k*32 +: 32] = ea[k];
          b4.pwdata_i[k*32 +: 32] = ew[k];
          b4.pstrb_i[k*4 +: 4] = es[k];
          b4.pwrite_i[k] = ewr[k];
          b4.psel_i[k] = 1'b1;
        end
      end
    end
    total++;
    if (served < 100) begin bad++; $display("FAIL rnd_served: got %0d want >= 100", served); end
  endtask

  initial begin
    preset = 1'b1;
    b2.psel_i = '0; b2.penable_i = '0; b2.pwrite_i = '0; b2.pstrb_i = '0;
    b2.paddr_i = '0; b2.pwdata_i = '0; b2.prdata_i = '0;
    b4.psel_i = '0; b4.penable_i = '0; b4.pwrite_i = '0; b4.pstrb_i = '0;
    b4.paddr_i = '0; b4.pwdata_i = '0;
    pend2[0] = 0; pend2[1] = 0;
    test_reset();
    test_single_write();
    test_contention();
    test_read_wait();
    test_drop_after_grant();
    test_reset_mid();
    test_random4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
